frame_pixel_reader: RTL and testbench
=====================================

Name: frame_pixel_reader

Overview:
- Streams pixels from the image data memory to the VGA RGB outputs.
- Places an IMG_W x IMG_H image at offset (X_OFF, Y_OFF) inside the active screen, with integer upscaling by 2^SCALE_LOG2.
- Accounts for the memory's read latency and supports grayscale or RGB332 pixel format.
- Sits between the VGA timing generator (h/v counters) and the DAC/RGB pins.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- IMG_W, 256, image width in memory words
- IMG_H, 256, image height in memory words
- X_OFF, 64, first screen column of image window
- Y_OFF, 0, first screen line of image window
- SCALE_LOG2, 0, upscale factor 2^SCALE_LOG2 (legal 0..2)
- ADDR_W, 19, memory address width
- BASE_ADDR, 0, address of image pixel (0,0)
- MEM_LAT, 1, memory read latency in cycles (legal >=1)
- BG_VAL, 8'h00, background level for active pixels outside the window

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- h_count  in  10  horizontal counter from timing generator
- v_count  in  10  vertical counter from timing generator
- mode  in  1  0 = grayscale, 1 = RGB332
- mem_addr  out  ADDR_W  read address to data memory
- mem_rd_en  out  1  read strobe, high for in-window pixels
- mem_data  in  8  read data, valid MEM_LAT cycles after mem_addr/mem_rd_en
- R  out  8  red
- G  out  8  green
- B  out  8  blue
- pix_valid  out  1  high when R/G/B carry image data (not background/blank)

Behaviour:
- Reset (rst_n low, async): R=G=B=0, pix_valid=0, mem_rd_en=0, mem_addr=BASE_ADDR, line_base=BASE_ADDR, sub-counters=0, pipeline flags cleared, mode_lat=0.
- Classification per cycle:
  - active = h_count<H_ACTIVE && v_count<V_ACTIVE.
  - in_win = active && X_OFF<=h_count<X_OFF+(IMG_W<<SCALE_LOG2) && Y_OFF<=v_count<Y_OFF+(IMG_H<<SCALE_LOG2).
- mem_rd_en is combinational = in_win. mem_addr is the registered address counter.
- Address generation (registered, no multipliers):
  - Each in_win cycle: if col_sub==2^SCALE_LOG2-1, addr+=1 and col_sub=0; else col_sub+=1.
  - Last window column of a line: col_sub=0.
    - If row_sub==2^SCALE_LOG2-1: line_base+=IMG_W, addr=line_base+IMG_W, row_sub=0.
    - Else: row_sub+=1, addr=line_base (line repeat).
  - v_count>=V_ACTIVE (vertical blank): addr=line_base=BASE_ADDR, col_sub=row_sub=0, mode_lat<=mode.
  - mode_lat is used for the whole frame, so a mid-frame mode change takes effect next frame.
- Pipeline:
  - active and in_win are delayed through an (MEM_LAT+1)-stage shift register.
  - Outputs are registered. Total latency from h/v count to R/G/B = MEM_LAT+1 cycles; the timing generator delays sync by the same amount.
- Output at the final stage:
  - in_win_d: pix_valid=1.
    - mode_lat=0: R=G=B=mem_data.
    - mode_lat=1: R={d[7:5],d[7:5],d[7:6]}, G={d[4:2],d[4:2],d[4:3]}, B={d[1:0]x4}.
  - active_d && !in_win_d: R=G=B=BG_VAL, pix_valid=0.
  - Otherwise (blank): R=G=B=0, pix_valid=0. Never X.
- Boundaries:
  - The window is clipped by H_ACTIVE/V_ACTIVE. Clipped pixels are not fetched, and the address only advances on fetched pixels.
  - For a right-clipped window, the line end is taken at the last visible window column and line_base still advances by IMG_W.
  - addr wraps modulo 2^ADDR_W.
  - Reset mid-frame: restart from BASE_ADDR, with the output blank until the pipeline refills.

Test Plan:
1. Defaults, grayscale, mem_data=addr[7:0] model with MEM_LAT=1 → at h=64,v=0, mem_addr=0; two cycles later R=G=B=0x00, pix_valid=1. At h=319, mem_addr=255 and the output is 0xFF. At h=320, output=BG_VAL, pix_valid=0.
2. Line advance: v=1, h=64 → mem_addr=256. After the final window pixel of frame (v=255), vertical blank → mem_addr=BASE_ADDR.
3. SCALE_LOG2=1, IMG_W=4, X_OFF=0 → addresses 0,0,1,1,2,2,3,3 on line 0, the same on line 1, and 4,4,5,... on line 2.
4. mode=1, mem_data=8'hE3 → R=8'hFF, G=8'h00, B=8'hFF. mode toggled mid-frame → output format unchanged until the next frame.
5. MEM_LAT=3 → the first valid pixel appears 4 cycles after h=X_OFF. Blank region outputs 0, with no X on R/G/B at any time.
6. rst_n pulsed low at h=100,v=50 → outputs immediately 0. After release, the next in-window fetch uses BASE_ADDR.

Source files
------------

// File: rtl/frame_pixel_reader.sv
// Streams image words from data memory onto the VGA RGB pins for a window inside
// the active area, with power-of-two upscaling and MEM_LAT+1 cycles of latency.
module frame_pixel_reader #(
    parameter int                H_ACTIVE   = 640,
    parameter int                V_ACTIVE   = 480,
    parameter int                IMG_W      = 256,
    parameter int                IMG_H      = 256,
    parameter int                X_OFF      = 64,
    parameter int                Y_OFF      = 0,
    parameter int                SCALE_LOG2 = 0,
    parameter int                ADDR_W     = 19,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                MEM_LAT    = 1,
    parameter logic [7:0]        BG_VAL     = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_data,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              pix_valid
);

    localparam int X_END = X_OFF + (IMG_W << SCALE_LOG2);
    localparam logic [31:0] X_LO   = 32'(X_OFF);
    localparam logic [31:0] X_HI   = 32'(X_END);
    localparam logic [31:0] Y_LO   = 32'(Y_OFF);
    localparam logic [31:0] Y_HI   = 32'(Y_OFF + (IMG_H << SCALE_LOG2));
    localparam logic [31:0] H_LIM  = 32'(H_ACTIVE);
    localparam logic [31:0] V_LIM  = 32'(V_ACTIVE);
    // Line end is the last column actually shown, so right-clipped windows still step rows.
    localparam logic [31:0] X_LAST = 32'(((X_END < H_ACTIVE) ? X_END : H_ACTIVE) - 1);
    localparam int SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic [31:0] h_w, v_w;
    logic        active, in_win, vblank;

    logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d;
    logic [SUB_W-1:0]  col_sub_q, col_sub_d, row_sub_q, row_sub_d;
    logic              mode_lat_q, mode_lat_d;
    logic [MEM_LAT-1:0] win_pipe_q, act_pipe_q;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              valid_q, valid_d;

    assign h_w    = {22'd0, h_count};
    assign v_w    = {22'd0, v_count};
    assign active = (h_w < H_LIM) && (v_w < V_LIM);
    assign in_win = active && (h_w >= X_LO) && (h_w < X_HI) && (v_w >= Y_LO) && (v_w < Y_HI);
    assign vblank = (v_w >= V_LIM);

    assign mem_rd_en = in_win && rst_n;
    assign mem_addr  = addr_q;
    assign R         = r_q;
    assign G         = g_q;
    assign B         = b_q;
    assign pix_valid = valid_q;

    always_comb begin
        addr_d      = addr_q;
        line_base_d = line_base_q;
        col_sub_d   = col_sub_q;
        row_sub_d   = row_sub_q;
        mode_lat_d  = mode_lat_q;
        if (vblank) begin
            addr_d      = BASE_ADDR;
            line_base_d = BASE_ADDR;
            col_sub_d   = '0;
            row_sub_d   = '0;
            mode_lat_d  = mode;
        end else if (in_win) begin
            if (h_w == X_LAST) begin
                col_sub_d = '0;
                if (row_sub_q == SUB_MAX) begin
                    line_base_d = line_base_q + ROW_STEP;
                    addr_d      = line_base_q + ROW_STEP;
                    row_sub_d   = '0;
                end else begin
                    row_sub_d = row_sub_q + 1'b1;
                    addr_d    = line_base_q;
                end
            end else if (col_sub_q == SUB_MAX) begin
                addr_d    = addr_q + 1'b1;
                col_sub_d = '0;
            end else begin
                col_sub_d = col_sub_q + 1'b1;
            end
        end
    end

    // Final pipeline stage lines up with mem_data for the fetch made MEM_LAT cycles earlier.
    always_comb begin
        r_d     = 8'h00;
        g_d     = 8'h00;
        b_d     = 8'h00;
        valid_d = 1'b0;
        if (win_pipe_q[MEM_LAT-1]) begin
            valid_d = 1'b1;
            if (mode_lat_q) begin
                r_d = {mem_data[7:5], mem_data[7:5], mem_data[7:6]};
                g_d = {mem_data[4:2], mem_data[4:2], mem_data[4:3]};
                b_d = {4{mem_data[1:0]}};
            end else begin
                r_d = mem_data;
                g_d = mem_data;
                b_d = mem_data;
            end
        end else if (act_pipe_q[MEM_LAT-1]) begin
            r_d = BG_VAL;
            g_d = BG_VAL;
            b_d = BG_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= BASE_ADDR;
            line_base_q <= BASE_ADDR;
            col_sub_q   <= '0;
            row_sub_q   <= '0;
            mode_lat_q  <= 1'b0;
            win_pipe_q  <= '0;
            act_pipe_q  <= '0;
            r_q         <= 8'h00;
            g_q         <= 8'h00;
            b_q         <= 8'h00;
            valid_q     <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            line_base_q   <= line_base_d;
            col_sub_q     <= col_sub_d;
            row_sub_q     <= row_sub_d;
            mode_lat_q    <= mode_lat_d;
            win_pipe_q[0] <= in_win;
            act_pipe_q[0] <= active;
            for (int i = 1; i < MEM_LAT; i++) begin
                win_pipe_q[i] <= win_pipe_q[i-1];
                act_pipe_q[i] <= act_pipe_q[i-1];
            end
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_frame_pixel_reader.sv
// Bench for frame_pixel_reader: three differently configured readers share one raster
// stream; expected addresses and pixels come from window geometry, not from counters.
module tb_frame_pixel_reader;

    localparam int ND = 3;
    localparam int P_HACT [ND] = '{640, 640, 6};
    localparam int P_VACT [ND] = '{480, 480, 5};
    localparam int P_W    [ND] = '{256, 4, 4};
    localparam int P_H    [ND] = '{256, 4, 4};
    localparam int P_XO   [ND] = '{64, 0, 3};
    localparam int P_YO   [ND] = '{0, 0, 2};
    localparam int P_SC   [ND] = '{0, 1, 0};
    localparam int P_LAT  [ND] = '{1, 3, 2};
    localparam logic [18:0] P_BASE [ND] = '{19'h00000, 19'h7FFFA, 19'h00100};
    localparam logic [7:0]  P_BG   [ND] = '{8'h00, 8'h5A, 8'h33};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] h_count = 10'd0;
    logic [9:0] v_count = 10'd480;
    logic       mode = 1'b0;

    logic [18:0] mem_addr_w [ND];
    logic        rd_w [ND];
    logic [7:0]  md_w [ND];
    logic [7:0]  r_w [ND];
    logic [7:0]  g_w [ND];
    logic [7:0]  b_w [ND];
    logic        pv_w [ND];
    logic [18:0] apipe [ND][4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        frame_pixel_reader #(
            .H_ACTIVE(P_HACT[gi]), .V_ACTIVE(P_VACT[gi]), .IMG_W(P_W[gi]), .IMG_H(P_H[gi]),
            .X_OFF(P_XO[gi]), .Y_OFF(P_YO[gi]), .SCALE_LOG2(P_SC[gi]), .ADDR_W(19),
            .BASE_ADDR(P_BASE[gi]), .MEM_LAT(P_LAT[gi]), .BG_VAL(P_BG[gi])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count), .mode(mode),
            .mem_addr(mem_addr_w[gi]), .mem_rd_en(rd_w[gi]), .mem_data(md_w[gi]),
            .R(r_w[gi]), .G(g_w[gi]), .B(b_w[gi]), .pix_valid(pv_w[gi])
        );
        // Memory content is the low address byte, returned MEM_LAT cycles after the request.
        assign md_w[gi] = apipe[gi][P_LAT[gi]-1][7:0];
    end

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            apipe[d][0] <= mem_addr_w[d];
            for (int k = 1; k < 4; k++) apipe[d][k] <= apipe[d][k-1];
        end
    end

    // Per cycle: {data_known, valid, r, g, b} for each reader, 26 bits each.
    logic [77:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int cur_d = 0;
    bit trust [ND];
    bit pend [ND];
    bit prev_vb [ND];
    bit prev_rst [ND];
    bit mode_f [ND];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d h=%0d v=%0d: got %h, expected %h",
                      tag, cur_d, h_count, v_count, got, exp);
    endtask

    function automatic logic [23:0] expand(input bit m, input logic [7:0] d);
        int rr, gg, bb;
        if (!m) return {d, d, d};
        rr = int'(d) / 32;
        gg = (int'(d) / 4) % 8;
        bb = int'(d) % 4;
        return {8'(rr * 32 + rr * 4 + rr / 2), 8'(gg * 32 + gg * 4 + gg / 2), 8'(bb * 85)};
    endfunction

    task automatic step(input int h, input int v, input bit m, input bit rst);
        logic [77:0] row, old;
        logic [25:0] e;
        logic [18:0] ea [ND];
        bit chk [ND];
        bit win [ND];
        bit act;
        int idx;
        @(posedge clk);
        #1;
        h_count = 10'(h);
        v_count = 10'(v);
        mode    = m;
        rst_n   = rst;
        row = '0;
        for (int d = 0; d < ND; d++) begin
            act = (h < P_HACT[d]) && (v < P_VACT[d]);
            win[d] = act && (h >= P_XO[d]) && (h < P_XO[d] + (P_W[d] << P_SC[d]))
                         && (v >= P_YO[d]) && (v < P_YO[d] + (P_H[d] << P_SC[d]));
            chk[d] = 1'b1;
            ea[d]  = P_BASE[d];
            if (!rst || prev_rst[d] || prev_vb[d]) ea[d] = P_BASE[d];
            else if (win[d] && trust[d])
                ea[d] = P_BASE[d] + 19'((((v - P_YO[d]) >> P_SC[d]) * P_W[d]) + ((h - P_XO[d]) >> P_SC[d]));
            else if (win[d] && pend[d]) ea[d] = P_BASE[d];
            else chk[d] = 1'b0;
            if (!rst) e = {1'b1, 1'b0, 24'h0};
            else if (win[d]) e = {chk[d], 1'b1, expand(mode_f[d], ea[d][7:0])};
            else if (act) e = {1'b1, 1'b0, P_BG[d], P_BG[d], P_BG[d]};
            else e = {1'b1, 1'b0, 24'h0};
            row[d*26 +: 26] = e;
        end
        exp_q.push_back(row);
        if (exp_q.size() > 8) void'(exp_q.pop_front());
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            cur_d = d;
            idx = exp_q.size() - 2 - P_LAT[d];
            if (!rst || idx < 0) e = {1'b1, 1'b0, 24'h0};
            else begin
                old = exp_q[idx];
                e = old[d*26 +: 26];
            end
            check("rd_en", 32'(rd_w[d]), 32'(win[d] && rst));
            if (chk[d]) check("addr", 32'(mem_addr_w[d]), 32'(ea[d]));
            check("pix_valid", 32'(pv_w[d]), 32'(e[24]));
            if (e[25]) check("rgb", {8'h0, r_w[d], g_w[d], b_w[d]}, {8'h0, e[23:0]});
            if (!rst) begin
                trust[d] = 1'b0;
                mode_f[d] = 1'b0;
                pend[d] = 1'b1;
                prev_rst[d] = 1'b1;
                prev_vb[d] = 1'b0;
            end else begin
                prev_rst[d] = 1'b0;
                if (win[d]) pend[d] = 1'b0;
                prev_vb[d] = (v >= P_VACT[d]);
                if (v >= P_VACT[d]) begin
                    trust[d] = 1'b1;
                    mode_f[d] = m;
                    pend[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic vblank(input bit m);
        int n;
        n = int'($urandom_range(3, 8));
        for (int k = 0; k < n; k++)
            step(int'($urandom_range(0, 1023)), int'($urandom_range(480, 524)),
                 (k == n - 1) ? m : bit'($urandom_range(0, 1)), 1'b1);
    endtask

    // Raster order within the line, with random blanking cycles slipped in between.
    task automatic scan_line(input int v, input int rst_from, input int rst_to);
        for (int h = 0; h <= 330; h++) begin
            if ($urandom_range(0, 5) == 0)
                step(int'($urandom_range(331, 1023)), v, bit'($urandom_range(0, 1)), 1'b1);
            step(h, v, bit'($urandom_range(0, 1)), !(h >= rst_from && h < rst_to));
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            trust[d] = 1'b0;
            pend[d] = 1'b1;
            prev_vb[d] = 1'b0;
            prev_rst[d] = 1'b1;
            mode_f[d] = 1'b0;
        end
        repeat (6) step(0, 480, 1'b0, 1'b0);
        for (int f = 0; f < 4; f++) begin
            vblank(bit'(f % 2));
            for (int v = 0; v < 10; v++) scan_line(v, -1, -1);
        end
        vblank(1'b1);
        scan_line(0, -1, -1);
        scan_line(1, -1, -1);
        // Jumping straight to line 50 skips rows, so spatial addresses are no longer predictable.
        for (int d = 0; d < ND; d++) trust[d] = 1'b0;
        scan_line(50, 100, 105);
        vblank(1'b0);
        for (int v = 0; v < 10; v++) scan_line(v, -1, -1);
        vblank(1'b1);
        scan_line(0, -1, -1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
